instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch front end that acts as the reading initiator for the single-port-read instruction memory. It owns the program counter and issues word reads to the memory, which has a 1-cycle registered read latency. Returned words are buffered in a small FIFO and handed to decode over a valid/ready handshake. Branch/jump redirects flush all buffered and in-flight fetches.

Parameters:
ADDR_W, 10, instruction memory word-address width (memory holds 2^ADDR_W words)
INSTR_W, 32, instruction width
RESET_PC, 32'h0000_0000, byte address fetched first after reset
FQ_DEPTH, 2, fetch FIFO depth (minimum 2, for full throughput)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
fetch_en  in  1  permits new memory reads; held low while the memory is being loaded
mem_rd_en  out  1  memory read strobe
mem_rd_addr  out  ADDR_W  memory word address
mem_rd_instr  in  INSTR_W  memory read data, valid the cycle after mem_rd_en
redirect_valid  in  1  redirect request from execute
redirect_pc  in  32  redirect target byte address
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts the instruction
if_instr  out  INSTR_W  instruction
if_pc  out  32  byte PC of if_instr

Behaviour:
- Reset (async, rst=1): pc_q=RESET_PC, in-flight flag=0, FIFO empty. Outputs: mem_rd_en=0, mem_rd_addr=0, if_valid=0, if_instr=0, if_pc=0. All state is held while rst=1.
- Issue condition:
  - issue = fetch_en & ~redirect_valid & (occ + inflight - pop < FQ_DEPTH)
  - pop = if_valid & if_ready
  - occ = FIFO count; inflight = 1 when a read was issued last cycle and not killed.
- mem_rd_en=issue (combinational). mem_rd_addr=pc_q[ADDR_W+1:2].
- On issue: pc_q += 4, modulo 2^32. The word address wraps naturally.
- In-flight tracking: on issue, register inflight=1 and req_pc=pc_q. The next cycle, if inflight is still 1, push {mem_rd_instr, req_pc} into the FIFO.
- FIFO: if_valid = ~empty. if_instr/if_pc show the head entry, and the head stays stable while if_valid & ~if_ready. Push and pop in the same cycle are allowed when full or empty. Overflow is impossible by the credit rule; any push into a full FIFO is a design error and must be asserted in simulation.
- Latency: an issue in cycle N gives data on the bus in N+1, which is pushed at the end of N+1, so if_valid rises in N+2.
- Throughput: with if_ready held high, one instruction per cycle in steady state.
- Redirect (redirect_valid=1 in cycle N):
  - pc_q <= {redirect_pc[31:2], 2'b00}; the low 2 bits are ignored.
  - FIFO cleared, so if_valid=0 in N+1.
  - A read in flight from N-1 is killed and its data is not pushed in N.
  - No issue in N. The first issue at the target is in N+1, and if_valid rises in N+3.
  - Redirect has priority over pop and push in the same cycle. A pop in cycle N is still a legal handshake for decode, but decode must discard it.
  - Back-to-back redirects: the last one wins.
- fetch_en low: no new issues. An in-flight read still completes and is pushed. FIFO contents are retained and drain normally. pc_q holds.
- rst asserted mid-operation: everything returns to reset values immediately. Any in-flight memory data is ignored.

Decomposition:
- Shared package (riscv_pkg): INSTR_W, ADDR_W, RESET_PC, and the NOP encoding 32'h0000_0013 for later decode use.
- Sub-module fetch_fifo: parameterized sync FIFO (WIDTH=INSTR_W+32, DEPTH=FQ_DEPTH) with push, pop, clear, full, empty and count ports. It is reset by the same asynchronous rst.

Test Plan:
- Release reset, fetch_en=1, if_ready=1, memory words[i]=i+0x100 -> mem_rd_en cycle 0 with addr 0; if_valid cycle 2 with if_instr=0x100 and if_pc=0; then one word per cycle at if_pc 4, 8, 12…
- Steady stream, drop if_ready for 3 cycles -> if_instr/if_pc frozen; at most 2 reads outstanding (occ+inflight ≤ 2); no word lost or duplicated after if_ready returns.
- redirect_valid with redirect_pc=0x40 while the FIFO is full and a read is in flight -> if_valid=0 the next cycle; first instruction delivered has if_pc=0x40 and data=word 16, 3 cycles after the redirect; stale words never appear.
- redirect_pc=0x43 -> fetch resumes at 0x40.
- RESET_PC=4·(2^ADDR_W − 1), stream 2 words -> mem_rd_addr wraps from all-ones to 0; if_pc wraps only at 2^32.
- fetch_en low for 5 cycles mid-stream -> no mem_rd_en; the in-flight word still delivered; resumes at the correct pc. Assert rst mid-stream -> outputs return to reset values the same cycle, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the instruction-side blocks.
package riscv_pkg;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned INSTR_W  = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with same-cycle push/pop and a synchronous clear.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      assert (!(push && full && !pop));
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= nxt(wptr);
      end
      if (do_pop) rptr <= nxt(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: owns the PC, reads the 1-cycle instruction memory and
// buffers returned words for decode; redirects flush everything in flight.
module instr_fetch #(
  parameter int unsigned ADDR_W   = riscv_pkg::ADDR_W,
  parameter int unsigned INSTR_W  = riscv_pkg::INSTR_W,
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [INSTR_W-1:0] mem_rd_instr,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc
);
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = INSTR_W + 32;

  logic [31:0]      pc_q, req_pc_q;
  logic             inflight_q;
  logic [CNT_W-1:0] occ;
  logic             full, empty, pop, push, issue;
  logic [SUM_W-1:0] credit;
  logic [ENT_W-1:0] head;

  assign pop    = if_valid & if_ready;
  // slots already spoken for: buffered words plus the read coming back
  assign credit = SUM_W'(occ) + SUM_W'(inflight_q) - SUM_W'(pop);
  assign issue  = ~rst & fetch_en & ~redirect_valid & (credit < SUM_W'(FQ_DEPTH));
  assign push   = inflight_q & ~redirect_valid;

  assign mem_rd_en   = issue;
  assign mem_rd_addr = rst ? '0 : pc_q[ADDR_W+1:2];

  assign if_valid = ~empty;
  assign if_instr = empty ? '0 : head[ENT_W-1:32];
  assign if_pc    = empty ? '0 : head[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + 32'd4;
        req_pc_q <= pc_q;
      end
    end
  end

  fetch_fifo #(.WIDTH(ENT_W), .DEPTH(FQ_DEPTH), .CNT_W(CNT_W)) u_fq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .din   ({mem_rd_instr, req_pc_q}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stream, backpressure, redirects, fetch_en
// gaps, mid-run reset, and word-address wrap on a second instance.
module tb_instr_fetch;
  logic        clk = 1'b0, rst = 1'b1;
  logic        fetch_en = 1'b0, redirect_valid = 1'b0, if_ready = 1'b1;
  logic [31:0] redirect_pc = '0;

  logic        mem_rd_en, if_valid;
  logic [9:0]  mem_rd_addr;
  logic [31:0] mem_rd_instr = '0, if_instr, if_pc;

  logic        w_rd_en, w_valid;
  logic [9:0]  w_rd_addr;
  logic [31:0] w_rd_instr = '0, w_instr, w_pc;

  int total = 0, passed = 0, fails = 0;

  always #5 clk = ~clk;

  // instruction memory models: word[i] = i + 0x100, 1-cycle registered read
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_instr <= {22'd0, mem_rd_addr} + 32'h100;
    if (w_rd_en)   w_rd_instr   <= {22'd0, w_rd_addr} + 32'h100;
  end

  instr_fetch dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_instr(mem_rd_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  instr_fetch #(.RESET_PC(32'h0000_0FFC)) dut_w (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .mem_rd_en(w_rd_en), .mem_rd_addr(w_rd_addr), .mem_rd_instr(w_rd_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(w_valid), .if_ready(if_ready), .if_instr(w_instr), .if_pc(w_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, " valid"}, 32'(if_valid), 32'd1);
    chk({tag, " pc"}, if_pc, pc);
    chk({tag, " instr"}, if_instr, instr);
  endtask

  task automatic rd(input string tag, input logic en, input logic [9:0] addr);
    chk({tag, " rd_en"}, 32'(mem_rd_en), 32'(en));
    if (en) chk({tag, " rd_addr"}, 32'(mem_rd_addr), 32'(addr));
  endtask

  initial begin
    fetch_en = 1'b1;
    #2;
    chk("rst rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst valid", 32'(if_valid), 32'd0);
    chk("rst instr", if_instr, 32'd0);
    chk("rst pc", if_pc, 32'd0);
    chk("rst w rd_addr", 32'(w_rd_addr), 32'd0);
    next; rst = 1'b0; #1;
    // c0..c4: cold start and steady stream
    rd("c0", 1'b1, 10'd0); chk("c0 valid", 32'(if_valid), 32'd0);
    chk("c0 w rd_addr", 32'(w_rd_addr), 32'h3FF);
    next; rd("c1", 1'b1, 10'd1); chk("c1 valid", 32'(if_valid), 32'd0);
    chk("c1 w rd_addr wrap", 32'(w_rd_addr), 32'd0);
    next; out("c2", 32'h0, 32'h100);
    chk("c2 w valid", 32'(w_valid), 32'd1);
    chk("c2 w pc", w_pc, 32'h0FFC); chk("c2 w instr", w_instr, 32'h4FF);
    next; out("c3", 32'h4, 32'h101);
    chk("c3 w pc", w_pc, 32'h1000); chk("c3 w instr", w_instr, 32'h100);
    next; out("c4", 32'h8, 32'h102); rd("c4", 1'b1, 10'd4);
    // c5..c7: decode stalls, head frozen, credit stops issue
    next; if_ready = 1'b0; #1; out("c5", 32'hC, 32'h103); rd("c5", 1'b0, 10'd0);
    next; out("c6", 32'hC, 32'h103); rd("c6", 1'b0, 10'd0);
    next; out("c7", 32'hC, 32'h103); rd("c7", 1'b0, 10'd0);
    next; if_ready = 1'b1; #1; out("c8", 32'hC, 32'h103); rd("c8", 1'b1, 10'd5);
    next; out("c9", 32'h10, 32'h104); rd("c9", 1'b1, 10'd6);
    next; out("c10", 32'h14, 32'h105);
    next; out("c11", 32'h18, 32'h106);
    // c12: redirect with a buffered word and a read returning
    next; if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    rd("c12", 1'b0, 10'd0); out("c12", 32'h1C, 32'h107);
    next; redirect_valid = 1'b0; if_ready = 1'b1; #1;
    chk("c13 valid", 32'(if_valid), 32'd0); rd("c13", 1'b1, 10'd16);
    next; chk("c14 valid", 32'(if_valid), 32'd0); rd("c14", 1'b1, 10'd17);
    next; out("c15", 32'h40, 32'h110);
    next; out("c16", 32'h44, 32'h111);
    // c17: misaligned redirect target
    next; redirect_valid = 1'b1; redirect_pc = 32'h43; #1;
    rd("c17", 1'b0, 10'd0); out("c17", 32'h48, 32'h112);
    next; redirect_valid = 1'b0; #1;
    chk("c18 valid", 32'(if_valid), 32'd0); rd("c18", 1'b1, 10'd16);
    next; chk("c19 valid", 32'(if_valid), 32'd0);
    next; out("c20", 32'h40, 32'h110);
    next; out("c21", 32'h44, 32'h111);
    // c22..c26: fetch_en low, in-flight word still delivered
    next; fetch_en = 1'b0; #1; rd("c22", 1'b0, 10'd0); out("c22", 32'h48, 32'h112);
    next; rd("c23", 1'b0, 10'd0); out("c23", 32'h4C, 32'h113);
    next; rd("c24", 1'b0, 10'd0); chk("c24 valid", 32'(if_valid), 32'd0);
    next; rd("c25", 1'b0, 10'd0);
    next; rd("c26", 1'b0, 10'd0); chk("c26 valid", 32'(if_valid), 32'd0);
    next; fetch_en = 1'b1; #1; rd("c27", 1'b1, 10'd20);
    next; chk("c28 valid", 32'(if_valid), 32'd0);
    next; out("c29", 32'h50, 32'h114);
    next; out("c30", 32'h54, 32'h115);
    // mid-run reset: outputs drop immediately, restart at RESET_PC
    rst = 1'b1; #1;
    chk("mrst rd_en", 32'(mem_rd_en), 32'd0);
    chk("mrst rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("mrst valid", 32'(if_valid), 32'd0);
    chk("mrst instr", if_instr, 32'd0);
    chk("mrst pc", if_pc, 32'd0);
    next; chk("mrst hold valid", 32'(if_valid), 32'd0);
    rst = 1'b0; #1; rd("r0", 1'b1, 10'd0); chk("r0 valid", 32'(if_valid), 32'd0);
    next; rd("r1", 1'b1, 10'd1);
    next; out("r2", 32'h0, 32'h100);
    next; out("r3", 32'h4, 32'h101);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
